// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM encoding,
// sizing helpers used at elaboration time.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digits needed to show the largest magnitude of a width-bit operand.
  function automatic int unsigned min_bcd_digits(input int unsigned width,
                                                 input int unsigned is_signed);
    longint unsigned maxv;
    int unsigned     digits;
    maxv   = (is_signed != 0) ? (64'd1 << (width - 1)) : ((64'd1 << width) - 64'd1);
    digits = 1;
    for (int unsigned i = 0; i < 20; i++) begin
      if (maxv >= 64'd10) begin
        maxv   = maxv / 64'd10;
        digits = digits + 1;
      end
    end
    return digits;
  endfunction

  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction cell: adds 3 to a BCD digit of 5 or more.
module add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = (d >= 4'd5) ? d + 4'd3 : d;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done
// handshake and optional sign-magnitude handling of two's complement input.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int CW = count_width(WIDTH);

  if (DIGITS < min_bcd_digits(WIDTH, (SIGNED != 0) ? 1 : 0)) begin : g_digits_warn
    $warning("bin_to_bcd_seq: DIGITS too small for WIDTH, large values will set ovf");
  end

  state_t                state, state_next;
  logic [CW-1:0]         count;
  logic [WIDTH-1:0]      sreg;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   corr;
  logic                  sign_q;
  logic                  ovf_q;
  logic                  neg;
  logic [WIDTH-1:0]      mag;
  logic                  load;

  // Negation is WIDTH bits unsigned, so the most-negative operand maps to 2^(WIDTH-1).
  assign neg  = (SIGNED != 0) && bin[WIDTH-1];
  assign mag  = neg ? (~bin + {{(WIDTH-1){1'b0}}, 1'b1}) : bin;
  assign load = start && ((state == IDLE) || (state == DONE));
  assign busy = (state == SHIFT);

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    add3 u_add3 (
      .d (scratch[4*g +: 4]),
      .q (corr[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == CW'(1)) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      sreg    <= '0;
      scratch <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      sign    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == DONE) begin
        bcd  <= scratch;
        sign <= sign_q;
        ovf  <= ovf_q;
        done <= 1'b1;
      end
      if (load) begin
        sreg    <= mag;
        scratch <= '0;
        count   <= CW'(WIDTH);
        sign_q  <= neg;
        ovf_q   <= 1'b0;
      end else if (state == SHIFT) begin
        scratch <= {corr[4*DIGITS-2:0], sreg[WIDTH-1]};
        sreg    <= {sreg[WIDTH-2:0], 1'b0};
        ovf_q   <= ovf_q | corr[4*DIGITS-1];
        count   <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: four parameterisations, arithmetic
// reference model and an expected-result queue popped on each done pulse.
module tb_bin_to_bcd_seq;

  typedef struct packed {
    logic [19:0] bcd;
    logic        sign;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  bin8 = '0;
  logic [15:0] bin16 = '0;
  logic        start8 = 1'b0, starts = 1'b0, start16 = 1'b0, start2 = 1'b0;

  logic        busy8, done8, sign8, ovf8;
  logic [11:0] bcd8;
  logic        busys, dones, signs, ovfs;
  logic [11:0] bcds;
  logic        busy16, done16, sign16, ovf16;
  logic [19:0] bcd16;
  logic        busy2, done2, sign2, ovf2;
  logic [7:0]  bcd2;

  int   total = 0;
  int   bad   = 0;
  int   sel   = 0;
  exp_t sb[$];
  exp_t cur;
  logic cur_done, cur_busy;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8), .busy(busy8), .done(done8),
    .sign(sign8), .bcd(bcd8), .ovf(ovf8));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) us (
    .clk(clk), .rst(rst), .start(starts), .bin(bin8), .busy(busys), .done(dones),
    .sign(signs), .bcd(bcds), .ovf(ovfs));
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u16 (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16), .busy(busy16), .done(done16),
    .sign(sign16), .bcd(bcd16), .ovf(ovf16));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin8), .busy(busy2), .done(done2),
    .sign(sign2), .bcd(bcd2), .ovf(ovf2));

  always_comb begin
    cur_done = 1'b0;
    cur_busy = 1'b0;
    cur      = '0;
    case (sel)
      0: begin cur_done = done8;  cur_busy = busy8;  cur = '{{8'h0, bcd8}, sign8, ovf8}; end
      1: begin cur_done = dones;  cur_busy = busys;  cur = '{{8'h0, bcds}, signs, ovfs}; end
      2: begin cur_done = done16; cur_busy = busy16; cur = '{bcd16, sign16, ovf16}; end
      default: begin cur_done = done2; cur_busy = busy2; cur = '{{12'h0, bcd2}, sign2, ovf2}; end
    endcase
  end

  function automatic int inst_width(input int inst);
    return (inst == 2) ? 16 : 8;
  endfunction

  // Reference by repeated division, independent of the shift-add algorithm.
  function automatic exp_t model(input int inst, input logic [15:0] v);
    exp_t        e;
    int unsigned m;
    int          digits;
    e      = '0;
    digits = (inst == 2) ? 5 : (inst == 3) ? 2 : 3;
    m      = (inst == 2) ? int'(v) : int'(v[7:0]);
    if (inst == 1 && v[7]) begin
      m      = 256 - int'(v[7:0]);
      e.sign = 1'b1;
    end
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e.ovf = (m != 0);
    return e;
  endfunction

  // Drive one conversion from a negedge; return outputs at done and the latency in negedges.
  task automatic do_conv(input int inst, input logic [15:0] v, output exp_t got, output int lat);
    sel = inst;
    sb.push_back(model(inst, v));
    if (inst == 2) bin16 = v; else bin8 = v[7:0];
    case (inst)
      0: start8 = 1'b1;
      1: starts = 1'b1;
      2: start16 = 1'b1;
      default: start2 = 1'b1;
    endcase
    lat = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0; starts = 1'b0; start16 = 1'b0; start2 = 1'b0;
      lat++;
    end while (!cur_done && lat < 60);
    got = cur;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy8, done8, sign8, ovf8, bcd8, busys, dones, signs, ovfs, bcds} !== '0 ||
        {busy16, done16, sign16, ovf16, bcd16, busy2, done2, sign2, ovf2, bcd2} !== '0) begin
      bad++;
      $display("FAIL reset_state: outputs u8=%h us=%h u16=%h u2=%h required all zero",
               {busy8, done8, sign8, ovf8, bcd8}, {busys, dones, signs, ovfs, bcds},
               {busy16, done16, sign16, ovf16, bcd16}, {busy2, done2, sign2, ovf2, bcd2});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency;
    int   lat, busy_cycles;
    exp_t e;
    sel = 0;
    sb.push_back(model(0, 16'd255));
    bin8 = 8'd255; start8 = 1'b1;
    lat = 0; busy_cycles = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      lat++;
      if (busy8) busy_cycles++;
    end while (!done8 && lat < 60);
    e = sb.pop_front();
    total++;
    if (lat != 10 || busy_cycles != 8) begin
      bad++;
      $display("FAIL latency_255: done after %0d negedges busy %0d cycles, required 10 and 8", lat, busy_cycles);
    end
    total++;
    if ({8'h0, bcd8, sign8, ovf8} !== e) begin
      bad++;
      $display("FAIL value_255: got bcd=%h ovf=%b, required bcd=%h ovf=%b", bcd8, ovf8, e.bcd, e.ovf);
    end
    @(negedge clk);
    total++;
    if (done8 !== 1'b0 || bcd8 !== 12'h255) begin
      bad++;
      $display("FAIL done_pulse: done=%b bcd=%h one cycle later, required done=0 bcd held 255", done8, bcd8);
    end
  endtask

  task automatic test_exhaustive;
    exp_t got, e;
    int   lat, errs;
    errs = 0;
    for (int v = 0; v < 256; v++) begin
      do_conv(0, 16'(v), got, lat);
      e = sb.pop_front();
      total++;
      if (got !== e || lat != 10) begin
        bad++; errs++;
        if (errs < 8)
          $display("FAIL exhaustive_%0d: got bcd=%h ovf=%b lat=%0d, required bcd=%h ovf=%b lat=10",
                   v, got.bcd, got.ovf, lat, e.bcd, e.ovf);
      end
    end
  endtask

  task automatic test_signed;
    logic [7:0] vals [6] = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h9C, 8'h01};
    exp_t got, e;
    int   lat;
    for (int i = 0; i < 6; i++) begin
      do_conv(1, {8'h0, vals[i]}, got, lat);
      e = sb.pop_front();
      total++;
      if (got !== e || lat != 10) begin
        bad++;
        $display("FAIL signed_%h: got sign=%b bcd=%h ovf=%b lat=%0d, required sign=%b bcd=%h ovf=%b lat=10",
                 vals[i], got.sign, got.bcd, got.ovf, lat, e.sign, e.bcd, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   n;
    sel = 0;
    sb.push_back(model(0, 16'd37));
    bin8 = 8'd37; start8 = 1'b1;
    for (n = 1; n <= 9; n++) begin
      @(negedge clk);
      bin8 = 8'(n * 13 + 100);
      if (n == 9) begin
        bin8 = 8'd173;
        sb.push_back(model(0, 16'd173));
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    bin8 = 8'd5;
    e = sb.pop_front();
    total++;
    if (done8 !== 1'b1 || busy8 !== 1'b1 || {8'h0, bcd8, sign8, ovf8} !== e) begin
      bad++;
      $display("FAIL b2b_first: done=%b busy=%b bcd=%h, required done=1 busy=1 bcd=%h",
               done8, busy8, bcd8, e.bcd);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done8 && n < 40);
    e = sb.pop_front();
    total++;
    if (n != 9 || {8'h0, bcd8, sign8, ovf8} !== e) begin
      bad++;
      $display("FAIL b2b_second: done after %0d cycles bcd=%h, required 9 cycles bcd=%h", n, bcd8, e.bcd);
    end
    repeat (12) @(negedge clk);
    total++;
    if (busy8 !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_idle: busy=%b queue=%0d, required busy=0 queue=0", busy8, sb.size());
    end
  endtask

  task automatic test_reset_mid;
    exp_t got, e;
    int   lat, pulses;
    sel = 0;
    sb.push_back(model(0, 16'd100));
    bin8 = 8'd100; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || bcd8 !== 12'h000 || ovf8 !== 1'b0 || sign8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b bcd=%h ovf=%b, required all zero", busy8, done8, bcd8, ovf8);
    end
    rst = 1'b0;
    pulses = 0;
    repeat (14) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_lost: %0d done pulses after reset, required 0", pulses);
    end
    do_conv(0, 16'd42, got, lat);
    e = sb.pop_front();
    total++;
    if (got !== e || got.bcd !== 20'h00042 || lat != 10) begin
      bad++;
      $display("FAIL after_reset_42: got bcd=%h lat=%0d, required bcd=042 lat=10", got.bcd, lat);
    end
  endtask

  task automatic test_sweep;
    int          insts [7] = '{2, 2, 2, 3, 3, 3, 3};
    logic [15:0] vals  [7] = '{16'd65535, 16'd10000, 16'd0, 16'd200, 16'd99, 16'd100, 16'd255};
    exp_t got, e;
    int   lat;
    for (int i = 0; i < 7; i++) begin
      do_conv(insts[i], vals[i], got, lat);
      e = sb.pop_front();
      total++;
      if (got !== e || lat != inst_width(insts[i]) + 2) begin
        bad++;
        $display("FAIL sweep_%0d_%0d: got bcd=%h ovf=%b lat=%0d, required bcd=%h ovf=%b lat=%0d",
                 insts[i], vals[i], got.bcd, got.ovf, lat, e.bcd, e.ovf, inst_width(insts[i]) + 2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_exhaustive;
    test_signed;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
